// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result FIFOs merged onto the CDB by a registered round-robin grant
// Ports: clk, rst (async, active-high); src_valid/src_ready/src_tag/src_data per-producer push
// interface (source i at [i*W +: W]); cdb_valid/cdb_tag/cdb_data registered broadcast, cdb_src
// granted source index; flush (only with CDB_ARB_FLUSH_EN) empties all FIFOs and clears the grant.
module cdb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int TAG_W      = 5,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [NUM_SRC-1:0]           src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]     src_tag,
  input  logic [NUM_SRC*DATA_W-1:0]    src_data,
  output logic                         cdb_valid,
  output logic [TAG_W-1:0]             cdb_tag,
  output logic [DATA_W-1:0]            cdb_data,
  output logic [$clog2(NUM_SRC)-1:0]   cdb_src
`ifdef CDB_ARB_FLUSH_EN
  ,
  input  logic                         flush
`endif
);
  localparam int SW = $clog2(NUM_SRC);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = TAG_W + DATA_W;
  logic flush_i;
`ifdef CDB_ARB_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif
  logic [EW-1:0] mem_q [NUM_SRC][FIFO_DEPTH];
  logic [EW-1:0] mem_d [NUM_SRC][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q [NUM_SRC];
  logic [PW-1:0] wr_ptr_d [NUM_SRC];
  logic [PW-1:0] rd_ptr_q [NUM_SRC];
  logic [PW-1:0] rd_ptr_d [NUM_SRC];
  logic [CW-1:0] cnt_q [NUM_SRC];
  logic [CW-1:0] cnt_d [NUM_SRC];
  logic [SW-1:0] rr_ptr_q, rr_ptr_d, win, cdb_src_q, cdb_src_d;
  logic [NUM_SRC-1:0] req, push, pop;
  logic any_req, grant, cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [EW-1:0] head;
  // Ready looks only at the registered count: a full FIFO refuses even when popped this cycle.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      req[i] = cnt_q[i] != '0;
      src_ready[i] = !rst && cnt_q[i] < CW'(FIFO_DEPTH);
      push[i] = src_valid[i] && src_ready[i] && !flush_i;
    end
  end
  // First requester at or above rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    win = rr_ptr_q;
    any_req = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!any_req && req[SW'((int'(rr_ptr_q) + k) % NUM_SRC)]) begin
        win = SW'((int'(rr_ptr_q) + k) % NUM_SRC);
        any_req = 1'b1;
      end
    end
  end
  assign head = mem_q[win][rd_ptr_q[win]];
  always_comb begin
    mem_d = mem_q;
    grant = any_req && !flush_i;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i] = grant && win == SW'(i);
      wr_ptr_d[i] = flush_i ? '0 : wr_ptr_q[i] + PW'(push[i]);
      rd_ptr_d[i] = flush_i ? '0 : rd_ptr_q[i] + PW'(pop[i]);
      cnt_d[i] = flush_i ? '0 : cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      if (push[i]) mem_d[i][wr_ptr_q[i]] = {src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]};
    end
    cdb_valid_d = grant;
    cdb_tag_d = grant ? head[EW-1 -: TAG_W] : cdb_tag_q;
    cdb_data_d = grant ? head[DATA_W-1:0] : cdb_data_q;
    cdb_src_d = grant ? win : cdb_src_q;
    rr_ptr_d = flush_i ? '0 : grant ? (win == SW'(NUM_SRC - 1) ? '0 : win + SW'(1)) : rr_ptr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '{default: '0};
      rd_ptr_q <= '{default: '0};
      cnt_q <= '{default: '0};
      rr_ptr_q <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q <= '0;
      cdb_data_q <= '0;
      cdb_src_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q <= cdb_tag_d;
      cdb_data_q <= cdb_data_d;
      cdb_src_q <= cdb_src_d;
    end
  end
  // Payload storage needs no reset: counts gate every read.
  always_ff @(posedge clk) mem_q <= mem_d;
  assign cdb_valid = cdb_valid_q;
  assign cdb_tag = cdb_tag_q;
  assign cdb_data = cdb_data_q;
  assign cdb_src = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard-based bench for cdb_arbiter
module tb_cdb_arbiter;
  localparam int N = 4;
  localparam int TW = 5;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush_tb = 1'b0;
  logic [N-1:0] src_valid = '0;
  logic [N-1:0] src_ready;
  logic [N*TW-1:0] src_tag = '0;
  logic [N*DW-1:0] src_data = '0;
  logic cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic [1:0] cdb_src;
  int errors = 0;
  int checks = 0;
  logic [TW+DW-1:0] exp_q [N][$];
  logic [TW+DW-1:0] e;
  logic [TW-1:0] seen [$];

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_SRC(N), .TAG_W(TW), .DATA_W(DW), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_tag(src_tag), .src_data(src_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
`ifdef CDB_ARB_FLUSH_EN
    , .flush(flush_tb)
`endif
  );

  // Scoreboard: compare each broadcast against its source queue, then record the handshakes
  // that the next rising edge will accept.
  always @(negedge clk) begin
    #4;
    if (rst) begin
      for (int i = 0; i < N; i++) exp_q[i].delete();
    end else begin
      if (cdb_valid) begin
        seen.push_back(cdb_tag);
        checks++;
        if (exp_q[cdb_src].size() == 0) begin
          errors++;
          $display("FAIL scoreboard: src %0d broadcast tag %h data %h, none expected", cdb_src, cdb_tag, cdb_data);
        end else begin
          e = exp_q[cdb_src].pop_front();
          if ({cdb_tag, cdb_data} !== e)
            begin errors++; $display("FAIL scoreboard: src %0d got %h/%h want %h/%h", cdb_src, cdb_tag, cdb_data, e[TW+DW-1 -: TW], e[DW-1:0]); end
        end
      end
      if (flush_tb) for (int i = 0; i < N; i++) exp_q[i].delete();
      else for (int i = 0; i < N; i++)
        if (src_valid[i] && src_ready[i]) exp_q[i].push_back({src_tag[i*TW +: TW], src_data[i*DW +: DW]});
    end
  end

  task automatic drive(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
    src_valid[i] = 1'b1;
    src_tag[i*TW +: TW] = t;
    src_data[i*DW +: DW] = d;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", cdb_valid); end
    checks++; if (cdb_tag !== '0) begin errors++; $display("FAIL reset_tag: got %h want 0", cdb_tag); end
    checks++; if (cdb_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", cdb_data); end
    checks++; if (cdb_src !== '0) begin errors++; $display("FAIL reset_src: got %h want 0", cdb_src); end
    checks++; if (src_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_low: got %b want 0000", src_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (src_ready !== 4'b1111) begin errors++; $display("FAIL reset_ready_high: got %b want 1111", src_ready); end
  endtask

  task automatic test_single;
    @(negedge clk); drive(1, 5'h03, 32'hDEAD_BEEF);
    @(negedge clk); src_valid = '0;
    @(negedge clk);
    checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", cdb_valid); end
    checks++; if (cdb_tag !== 5'h03) begin errors++; $display("FAIL single_tag: got %h want 03", cdb_tag); end
    checks++; if (cdb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", cdb_data); end
    checks++; if (cdb_src !== 2'd1) begin errors++; $display("FAIL single_src: got %0d want 1", cdb_src); end
    @(negedge clk);
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b want 0", cdb_valid); end
  endtask

  task automatic test_round_robin;
    for (int pass = 0; pass < 2; pass++) begin
      // steer rr_ptr: a lone grant to src 3 gives 0, a lone grant to src 1 gives 2
      @(negedge clk); drive(pass == 0 ? 3 : 1, 5'h1F, 32'h5);
      @(negedge clk); src_valid = '0;
      repeat (2) @(negedge clk);
      seen.delete();
      for (int i = 0; i < N; i++) drive(i, TW'(i + 1), 32'hA000_0000 + i);
      @(negedge clk); src_valid = '0;
      repeat (5) @(negedge clk);
      checks++;
      if (seen.size() != 4) begin errors++; $display("FAIL rr_count pass %0d: got %0d want 4", pass, seen.size()); end
      else for (int k = 0; k < 4; k++) begin
        checks++;
        if (seen[k] !== TW'((k + 2 * pass) % 4 + 1))
          begin errors++; $display("FAIL rr_order pass %0d slot %0d: got %0d want %0d", pass, k, seen[k], (k + 2 * pass) % 4 + 1); end
      end
    end
  endtask

  task automatic test_backpressure;
    logic saw_full = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (src_ready[0] === 1'b0) saw_full = 1'b1;
      for (int i = 0; i < N; i++) drive(i, {i[1:0], c[2:0]}, {i[7:0], c[23:0]});
    end
    @(negedge clk); src_valid = '0;
    repeat (12) @(negedge clk);
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL bp_ready0: got never-low want low when full"); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin errors++; $display("FAIL bp_lost src %0d: got %0d undelivered want 0", i, exp_q[i].size()); end
    end
  endtask

  task automatic test_push_pop;
    @(negedge clk); drive(3, 5'h07, 32'h7777);
    @(negedge clk); drive(3, 5'h08, 32'h8888);
    @(negedge clk);
    checks++; if (cdb_tag !== 5'h07 || cdb_valid !== 1'b1) begin errors++; $display("FAIL pp_first: got %b/%h want 1/07", cdb_valid, cdb_tag); end
    checks++; if (src_ready[3] !== 1'b1) begin errors++; $display("FAIL pp_ready: got %b want 1", src_ready[3]); end
    drive(3, 5'h09, 32'h9999);
    @(negedge clk); src_valid = '0;
    checks++; if (cdb_tag !== 5'h08 || cdb_src !== 2'd3) begin errors++; $display("FAIL pp_second: got %h/%0d want 08/3", cdb_tag, cdb_src); end
    checks++; if (src_ready[3] !== 1'b1) begin errors++; $display("FAIL pp_ready2: got %b want 1", src_ready[3]); end
    @(negedge clk);
    checks++; if (cdb_tag !== 5'h09 || cdb_valid !== 1'b1) begin errors++; $display("FAIL pp_third: got %b/%h want 1/09", cdb_valid, cdb_tag); end
    @(negedge clk);
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL pp_empty: got %b want 0", cdb_valid); end
  endtask

  task automatic test_reset_midstream;
    @(negedge clk); for (int i = 0; i < N; i++) drive(i, TW'(5'h10 + i), 32'hC0DE_0000 + i);
    @(negedge clk); for (int i = 0; i < N; i++) drive(i, TW'(5'h14 + i), 32'hC0DE_0010 + i);
    @(negedge clk); src_valid = '0;
    checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 5'h10) begin errors++; $display("FAIL mid_pre: got %b/%h want 1/10", cdb_valid, cdb_tag); end
    #2 rst = 1'b1;
    #1;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", cdb_valid); end
    checks++; if (cdb_tag !== '0 || cdb_data !== '0) begin errors++; $display("FAIL mid_payload: got %h/%h want 0/0", cdb_tag, cdb_data); end
    checks++; if (src_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready_low: got %b want 0000", src_ready); end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL mid_stale cycle %0d: got %b want 0", c, cdb_valid); end
      if (c == 0) begin
        checks++; if (src_ready !== 4'b1111) begin errors++; $display("FAIL mid_ready_high: got %b want 1111", src_ready); end
      end
    end
  endtask

`ifdef CDB_ARB_FLUSH_EN
  task automatic test_flush;
    @(negedge clk); for (int i = 0; i < N; i++) drive(i, TW'(5'h08 + i), 32'hF000_0000 + i);
    @(negedge clk); src_valid = '0; drive(0, 5'h0C, 32'hF000_000C); drive(1, 5'h0D, 32'hF000_000D);
    @(negedge clk); src_valid = '0; drive(2, 5'h1B, 32'hF000_001B); flush_tb = 1'b1;
    @(negedge clk); src_valid = '0; flush_tb = 1'b0; seen.delete();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", cdb_valid); end
    checks++; if (src_ready !== 4'b1111) begin errors++; $display("FAIL flush_ready: got %b want 1111", src_ready); end
    repeat (4) @(negedge clk);
    checks++; if (seen.size() != 0) begin errors++; $display("FAIL flush_stale: got %0d broadcasts want 0", seen.size()); end
    for (int i = 0; i < N; i++) drive(i, TW'(i + 1), 32'hB000_0000 + i);
    @(negedge clk); src_valid = '0;
    repeat (5) @(negedge clk);
    checks++;
    if (seen.size() != 4) begin errors++; $display("FAIL flush_rr_count: got %0d want 4", seen.size()); end
    else for (int k = 0; k < 4; k++) begin
      checks++;
      if (seen[k] !== TW'(k + 1)) begin errors++; $display("FAIL flush_rr slot %0d: got %0d want %0d", k, seen[k], k + 1); end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_push_pop;
    test_reset_midstream;
`ifdef CDB_ARB_FLUSH_EN
    test_flush;
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Result-collection stage directly upstream of `common_data_bus`. It accepts completed results (tag + data) from up to NUM_SRC functional units (ALU, multiplier, load unit, branch unit) and buffers each source in a small private FIFO. Each cycle it grants one buffered result by round-robin and presents it, registered, as the single valid/tag/data triple that drives the CDB register's `valid_in`/`tag_in`/`data_in`.

## Interface

Parameters:
- NUM_SRC, 4, number of producer ports (2..8)
- TAG_W, 5, reservation-station tag width
- DATA_W, 32, result width
- FIFO_DEPTH, 2, entries per source FIFO (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- src_valid  in  NUM_SRC  per-source result valid
- src_ready  out  NUM_SRC  per-source accept; bit i = FIFO i not full
- src_tag  in  NUM_SRC*TAG_W  source i tag at bits [i*TAG_W +: TAG_W]
- src_data  in  NUM_SRC*DATA_W  source i data at bits [i*DATA_W +: DATA_W]
- cdb_valid  out  1  registered broadcast valid, to CDB `valid_in`
- cdb_tag  out  TAG_W  registered broadcast tag
- cdb_data  out  DATA_W  registered broadcast data
- cdb_src  out  clog2(NUM_SRC)  index of the granted source (debug/perf)
- flush  in  1  present only with CDB_ARB_FLUSH_EN

## Operation

- Push: when src_valid[i] & src_ready[i] at a rising edge, {tag, data} is written into FIFO i.
- src_ready[i] = (count[i] < FIFO_DEPTH). It depends only on the registered count, with no same-cycle pop credit. A full FIFO refuses a push even if it is popped that cycle.
- src_ready is forced to all-zero while rst is high.
- Arbitration is combinational over the FIFO heads:
  - Request vector req[i] = (count[i] != 0).
  - Scan from rr_ptr upward, modulo NUM_SRC. The first set bit wins.
- Grant at the rising edge:
  - cdb_valid ← 1; cdb_tag and cdb_data ← the winner's head; cdb_src ← winner.
  - The winner's FIFO pops.
  - rr_ptr ← (winner+1) mod NUM_SRC.
- No request:
  - cdb_valid ← 0.
  - cdb_tag, cdb_data and cdb_src hold their last values.
  - rr_ptr unchanged.
- Simultaneous push and pop on the same FIFO: count unchanged, order preserved. The popped entry is the old head; the new entry is appended at the tail.
- Per-source order is strictly FIFO. There is no ordering guarantee across sources.
- Pointer and count arithmetic:
  - Read and write pointers are clog2(FIFO_DEPTH) bits and wrap naturally.
  - count is clog2(FIFO_DEPTH)+1 bits and never exceeds FIFO_DEPTH.
- There is no backpressure from the CDB; exactly one result is broadcast per cycle whenever any FIFO is non-empty.

## Timing

- Reset (asynchronous, immediate on rst rising):
  - All counts and pointers 0; rr_ptr 0.
  - cdb_valid 0, cdb_tag 0, cdb_data 0, cdb_src 0.
- First edge after rst deasserts: src_ready = all ones.
- Latency with no contention: result handshaked at edge E is visible on cdb_valid/tag/data after edge E+1. The CDB register then re-registers it after E+2.
- Throughput:
  - Per source: 1 result/cycle sustained, because FIFO_DEPTH ≥ 2 hides the non-credited ready.
  - Aggregate: 1 result/cycle.
- Worst-case wait for the head of a non-empty FIFO: NUM_SRC−1 grants.
- Reset mid-operation: all buffered results are discarded and cdb_valid drops in the same cycle (asynchronous).

## Configuration

- CDB_ARB_FLUSH_EN defined:
  - Adds the `flush` input, used for branch mispredict recovery.
  - flush high at an edge empties all FIFOs, clears cdb_valid to 0, and resets rr_ptr to 0.
  - Any push in that same cycle is dropped.
  - cdb_tag, cdb_data and cdb_src hold their values.
  - src_ready remains count-based, so it is all ones the cycle after the flush.
- Not defined: no `flush` port; state is cleared only by rst.

## Test plan

- Reset: assert rst mid-stream with FIFO 2 holding 2 entries → cdb_valid=0, cdb_tag=0, cdb_data=0 immediately. After release, src_ready=4'b1111 and no stale result is ever broadcast.
- Single source: src 1 pushes tag 5'h03 / 32'hDEAD_BEEF at edge E → cdb_valid=1, cdb_tag=3, cdb_data=DEADBEEF, cdb_src=1 after E+1, then cdb_valid=0.
- Round-robin: all 4 sources push at the same edge with tags 1, 2, 3, 4 and rr_ptr=0 → broadcasts in order 1, 2, 3, 4 on 4 consecutive cycles. A repeat with rr_ptr=2 → order 3, 4, 1, 2.
- Full FIFO and backpressure: hold src_valid[0]=1 with src 1–3 also continuously pushing → src_ready[0] deasserts when count[0]=2. No tag is lost or duplicated, and per-source order is preserved (scoreboard check).
- Simultaneous push and pop: with count[3]=1, push at the edge where source 3 is granted → count stays 1, and the next grant to source 3 returns the newly pushed tag.
- Flush (with CDB_ARB_FLUSH_EN): load 6 entries across the FIFOs, pulse flush for one cycle → cdb_valid=0 the next cycle, all counts 0, rr_ptr 0, and no pre-flush tag is ever broadcast afterwards.
